// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a single handshaked
// 16-bit x 9-bit-address memory. Port 0 is instruction fetch, port 1 is
// load/store data. One transaction is outstanding at a time.
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   req0/req1            level requests, held until the matching done
//   rwn0/rwn1            1 = read, 0 = write
//   addr0/addr1          9-bit request addresses
//   wdata0/wdata1        16-bit write data
//   done0/done1          one-cycle completion pulses
//   rdata0/rdata1        read data, updated only on that port's read done
//   busy                 high whenever the sequencer is not idle
//   mem_start            one-cycle start strobe to the memory
//   mem_rwn              memory read/write select (from command register)
//   mem_address          memory address (from command register)
//   mem_data_in          memory write data (from command register)
//   mem_data_out         memory read data
//   mem_ready            memory idle flag (1 = idle)
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise port 1 has fixed priority over port 0.

module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        rwn0,
    input  logic        rwn1,
    input  logic [8:0]  addr0,
    input  logic [8:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        mem_start,
    output logic        mem_rwn,
    output logic [8:0]  mem_address,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        cmd_rwn;
    logic [8:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_port;

    logic        load;
    logic        capture;
    logic        grant_port;

`ifdef MEM_ARB_RR_EN
    // Port preferred on the next contended grant; flips to the
    // loser of every grant so two persistent requesters alternate.
    logic        prio;

    always_comb begin
        grant_port = 1'b0;
        if (req0 && req1)
            grant_port = prio;
        else
            grant_port = req1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prio <= 1'b0;
        else if (load)
            prio <= ~grant_port;
    end
`else
    // Fixed priority: the data port wins whenever it is requesting.
    always_comb begin
        grant_port = req1;
    end
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        mem_start = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_start = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    capture   = cmd_rwn;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done0     = ~cmd_port;
                done1     = cmd_port;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_rwn   <= 1'b0;
            cmd_addr  <= 9'd0;
            cmd_wdata <= 16'd0;
            cmd_port  <= 1'b0;
        end else if (load) begin
            cmd_port  <= grant_port;
            cmd_rwn   <= grant_port ? rwn1   : rwn0;
            cmd_addr  <= grant_port ? addr1  : addr0;
            cmd_wdata <= grant_port ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0 <= 16'd0;
            rdata1 <= 16'd0;
        end else if (capture) begin
            if (cmd_port)
                rdata1 <= mem_data_out;
            else
                rdata0 <= mem_data_out;
        end
    end

    assign busy        = (state != ST_IDLE);
    assign mem_rwn     = cmd_rwn;
    assign mem_address = cmd_addr;
    assign mem_data_in = cmd_wdata;

endmodule
